// File: rtl/cheri_dmem_responder.sv
// Data-memory responder for the CHERI core: word SRAM plus tag flops, in-order
// responses after a fixed latency, grant throttled by an outstanding counter.
module cheri_dmem_responder #(
  parameter logic [31:0] AddrBase       = 32'h2000_0000,
  parameter int unsigned DepthW         = 12,
  parameter int unsigned RespLatency    = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  input  logic        data_is_cap_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [32:0] data_wdata_i,
  input  logic        stall_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [32:0] data_rdata_o,
  output logic        data_err_o,
  output logic [2:0]  outstanding_o
);
  localparam int unsigned Words    = 1 << DepthW;
  localparam logic [32:0] WinBytes = 33'd4 << DepthW;
  localparam logic [2:0]  MaxOut   = 3'(MaxOutstanding);

  logic [31:0]       offset;
  logic              in_win, cap_bad, acc_err, gnt, wr_en, rvalid;
  logic [DepthW-1:0] idx;
  logic [2:0]        cnt_d, cnt_q;
  logic [Words-1:0]  tag_d, tag_q;
  logic [31:0]       mem [Words];
  logic [31:0]       sram_rdata;
  logic              s0_vld_d, s0_vld_q, s0_err_d, s0_err_q;
  logic              s0_blank_d, s0_blank_q, s0_tag_d, s0_tag_q;
  logic [32:0]       s0_rdata;

  // The lower bound compare keeps addresses below the window from wrapping into it.
  always_comb begin
    offset  = data_addr_i - AddrBase;
    in_win  = (data_addr_i >= AddrBase) && ({1'b0, offset} < WinBytes);
    idx     = offset[DepthW+1:2];
    cap_bad = data_is_cap_i && ((data_addr_i[1:0] != 2'b00) || (data_be_i != 4'hF));
    acc_err = !in_win || cap_bad;
    gnt     = rst_ni && data_req_i && !stall_i && (cnt_q < MaxOut);
    wr_en   = gnt && data_we_i && !acc_err;
  end

  always_comb begin
    tag_d = tag_q;
    if (wr_en) begin
      if (data_is_cap_i) begin
        tag_d[idx] = data_wdata_i[32];
      end else begin
        tag_d[{idx[DepthW-1:1], 1'b0}] = 1'b0;
        tag_d[{idx[DepthW-1:1], 1'b1}] = 1'b0;
      end
    end
  end

  always_comb begin
    s0_vld_d   = gnt;
    s0_err_d   = acc_err;
    s0_blank_d = acc_err || data_we_i;
    s0_tag_d   = data_is_cap_i && tag_q[idx];
    case ({gnt, rvalid})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_i[b]) mem[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
      end
    end
    if (gnt) sram_rdata <= mem[idx];
  end

  // Grant stage: first response slot sits alongside the SRAM read port.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= 3'd0;
      tag_q      <= '0;
      s0_vld_q   <= 1'b0;
      s0_err_q   <= 1'b0;
      s0_blank_q <= 1'b1;
      s0_tag_q   <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      tag_q      <= tag_d;
      s0_vld_q   <= s0_vld_d;
      s0_err_q   <= s0_err_d;
      s0_blank_q <= s0_blank_d;
      s0_tag_q   <= s0_tag_d;
    end
  end

  assign s0_rdata = s0_blank_q ? 33'd0 : {s0_tag_q, sram_rdata};

  // Remaining latency stages shift {valid, err, rdata} towards the outputs.
  if (RespLatency > 1) begin : g_pipe
    localparam int unsigned N = RespLatency - 1;
    logic [N-1:0] vld_d, vld_q, err_d, err_q;
    logic [32:0]  rdata_d [N];
    logic [32:0]  rdata_q [N];

    always_comb begin
      vld_d      = '0;
      err_d      = '0;
      vld_d[0]   = s0_vld_q;
      err_d[0]   = s0_err_q;
      rdata_d[0] = s0_rdata;
      for (int i = 1; i < N; i++) begin
        vld_d[i]   = vld_q[i-1];
        err_d[i]   = err_q[i-1];
        rdata_d[i] = rdata_q[i-1];
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vld_q <= '0;
        err_q <= '0;
        for (int i = 0; i < N; i++) rdata_q[i] <= 33'd0;
      end else begin
        vld_q <= vld_d;
        err_q <= err_d;
        for (int i = 0; i < N; i++) rdata_q[i] <= rdata_d[i];
      end
    end

    assign rvalid       = vld_q[N-1];
    assign data_err_o   = err_q[N-1];
    assign data_rdata_o = rdata_q[N-1];
  end else begin : g_direct
    assign rvalid       = s0_vld_q;
    assign data_err_o   = s0_err_q;
    assign data_rdata_o = s0_rdata;
  end

  assign data_gnt_o    = gnt;
  assign data_rvalid_o = rvalid;
  assign outstanding_o = cnt_q;

  assert property (@(posedge clk_i) disable iff (!rst_ni) rvalid |-> (cnt_q != 3'd0));
  assert property (@(posedge clk_i) disable iff (!rst_ni) cnt_q <= MaxOut);
endmodule

// File: tb/tb_cheri_dmem_responder.sv
// Randomized bench for cheri_dmem_responder: two instances (latency 1 and 3),
// checked every cycle against a transaction-level memory/tag/response model.
module tb_cheri_dmem_responder;
  localparam logic [31:0] BASE = 32'h2000_0000;
  localparam int          DW   = 12;
  localparam longint      WIN  = longint'(4) << DW;
  localparam int          MAXO = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, is_cap = 1'b0, we = 1'b0, stall = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [32:0] wdata = 33'h0;
  int          sel = 0;

  logic        req_a, req_b, gnt_a, gnt_b, rv_a, rv_b, err_a, err_b;
  logic [32:0] rd_a, rd_b;
  logic [2:0]  os_a, os_b;
  logic        gnt, rv, err;
  logic [32:0] rd;
  logic [2:0]  os;

  always #5 clk = ~clk;

  assign req_a = req && (sel == 0);
  assign req_b = req && (sel == 1);
  assign gnt   = (sel == 1) ? gnt_b : gnt_a;
  assign rv    = (sel == 1) ? rv_b  : rv_a;
  assign err   = (sel == 1) ? err_b : err_a;
  assign rd    = (sel == 1) ? rd_b  : rd_a;
  assign os    = (sel == 1) ? os_b  : os_a;

  cheri_dmem_responder #(.AddrBase(BASE), .DepthW(DW), .RespLatency(1), .MaxOutstanding(MAXO)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req_a), .data_is_cap_i(is_cap), .data_we_i(we),
    .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata), .stall_i(stall),
    .data_gnt_o(gnt_a), .data_rvalid_o(rv_a), .data_rdata_o(rd_a), .data_err_o(err_a),
    .outstanding_o(os_a));

  cheri_dmem_responder #(.AddrBase(BASE), .DepthW(DW), .RespLatency(3), .MaxOutstanding(MAXO)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req_b), .data_is_cap_i(is_cap), .data_we_i(we),
    .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata), .stall_i(stall),
    .data_gnt_o(gnt_b), .data_rvalid_o(rv_b), .data_rdata_o(rd_b), .data_err_o(err_b),
    .outstanding_o(os_b));

  typedef struct {
    logic [32:0] rdata;
    logic        err;
    bit          chk_data;
    int          due;
  } rsp_t;

  rsp_t        q[$];
  bit [31:0]   mem_m [int];
  bit          tag_m [int];
  int          cyc = 0, n_chk = 0, n_pass = 0;
  bit          acc;
  logic [32:0] last_rdata = 33'h0;
  logic        last_err = 1'b0;
  int          pool [14] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 4094, 4095};

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic int lat();
    return (sel == 1) ? 3 : 1;
  endfunction

  function automatic bit tag_of(int key);
    return tag_m.exists(key) ? tag_m[key] : 1'b0;
  endfunction

  // Reference behaviour of one accepted access, in acceptance order.
  task automatic model_accept();
    longint    a = longint'(addr);
    bit        inwin = (a >= longint'(BASE)) && (a - longint'(BASE) < WIN);
    bit        e = !inwin || (is_cap && (addr[1:0] != 2'b00 || be != 4'hF));
    int        key = sel * 65536 + (inwin ? int'((a - longint'(BASE)) >> 2) : 0);
    bit [31:0] w;
    rsp_t      r;
    r.rdata = 33'h0; r.err = e; r.chk_data = 1'b1; r.due = cyc + lat();
    if (!e && we) begin
      if (mem_m.exists(key) || be == 4'hF) begin
        w = mem_m.exists(key) ? mem_m[key] : 32'h0;
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
        mem_m[key] = w;
      end
      if (is_cap) tag_m[key] = wdata[32];
      else begin
        tag_m[key & ~1] = 1'b0;
        tag_m[key | 1]  = 1'b0;
      end
    end else if (!e) begin
      r.chk_data = mem_m.exists(key);
      r.rdata[31:0] = r.chk_data ? mem_m[key] : 32'h0;
      r.rdata[32] = is_cap && tag_of(key);
    end
    q.push_back(r);
  endtask

  // One clock: called just after a falling edge with inputs already applied.
  task automatic cycle();
    bit exp_rv;
    #1;
    check("gnt", 64'(gnt), 64'(req && !stall && (q.size() < MAXO)));
    check("outstanding", 64'(os), 64'(q.size()));
    exp_rv = (q.size() != 0) && (q[0].due == cyc);
    check("rvalid", 64'(rv), 64'(exp_rv));
    if (exp_rv) begin
      check("rsp_err", 64'(err), 64'(q[0].err));
      if (q[0].chk_data) check("rsp_rdata", 64'(rd), 64'(q[0].rdata));
      else check("rsp_tag", 64'(rd[32]), 64'(q[0].rdata[32]));
      last_rdata = rd;
      last_err = err;
      void'(q.pop_front());
    end
    acc = req && (gnt === 1'b1);
    if (acc) model_accept();
    cyc++;
    @(negedge clk);
  endtask

  task automatic issue(input bit c, input bit w, input bit [3:0] b, input bit [31:0] a,
                       input bit [32:0] d, input int nstall, output int waited);
    is_cap = c; we = w; be = b; addr = a; wdata = d; req = 1'b1;
    waited = 0;
    do begin
      stall = (waited < nstall);
      cycle();
      waited++;
    end while (!acc && waited < 40);
    if (!acc) check("issue_timeout", 64'(0), 64'(1));
    req = 1'b0; stall = 1'b0;
  endtask

  task automatic wr(input bit [31:0] a, input bit [32:0] d, input bit [3:0] b, input bit c);
    int w;
    issue(c, 1'b1, b, a, d, 0, w);
  endtask

  task automatic rdt(input bit [31:0] a, input bit c);
    int w;
    issue(c, 1'b0, 4'hF, a, 33'h0, 0, w);
  endtask

  task automatic drain();
    int k = 0;
    req = 1'b0;
    while (q.size() != 0 && k < 50) begin cycle(); k++; end
    if (q.size() != 0) check("drain_timeout", 64'(q.size()), 64'(0));
    cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = 1'b0; stall = 1'b0;
    q.delete();
    tag_m.delete();
    cycle();
    check("rst_rdata", 64'(rd), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic prewrite();
    foreach (pool[i]) wr(BASE + 32'(pool[i] * 4), {1'b0, $urandom()}, 4'hF, 1'b0);
  endtask

  task automatic random_phase(int n);
    int w, r;
    bit [31:0] a;
    bit [3:0] b;
    for (int t = 0; t < n; t++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        case ($urandom_range(0, 3))
          0:       a = BASE - 32'd4;
          1:       a = BASE + 32'(WIN);
          2:       a = 32'hFFFF_FFFC;
          default: a = BASE + 32'(WIN) + 32'd8;
        endcase
      end else begin
        a = BASE + 32'(pool[$urandom_range(0, 13)] * 4);
        if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
      end
      b = ($urandom_range(0, 2) == 0) ? 4'($urandom()) : 4'hF;
      issue(1'($urandom()), 1'($urandom()), b, a, {1'($urandom()), $urandom()},
            ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0, w);
      if ($urandom_range(0, 3) == 0) cycle();
    end
    drain();
  endtask

  initial begin
    int w;
    @(negedge clk);
    do_reset();

    // Latency-1 instance: directed cases first.
    sel = 0;
    prewrite();
    drain();
    issue(1'b0, 1'b1, 4'hF, BASE + 32'h10, {1'b0, 32'hDEAD_BEEF}, 0, w);
    check("wr_gnt_same_cycle", 64'(w), 64'(1));
    issue(1'b0, 1'b0, 4'hF, BASE + 32'h10, 33'h0, 0, w);
    check("rd_gnt_same_cycle", 64'(w), 64'(1));
    drain();
    check("rd_deadbeef", 64'(last_rdata), 64'({1'b0, 32'hDEAD_BEEF}));
    check("rd_deadbeef_err", 64'(last_err), 64'(0));

    wr(BASE + 32'h20, {1'b1, 32'h1234_5678}, 4'hF, 1'b1);
    wr(BASE + 32'h24, {1'b1, 32'h0}, 4'hF, 1'b1);
    rdt(BASE + 32'h20, 1'b1);
    drain();
    check("cap_tag_set", 64'(last_rdata), 64'({1'b1, 32'h1234_5678}));
    wr(BASE + 32'h27, {1'b0, 32'h0000_00AB}, 4'b0001, 1'b0);
    rdt(BASE + 32'h20, 1'b1);
    drain();
    check("granule_clr_lo", 64'(last_rdata), 64'({1'b0, 32'h1234_5678}));
    rdt(BASE + 32'h24, 1'b1);
    drain();
    check("granule_clr_hi", 64'(last_rdata), 64'({1'b0, 32'h0000_00AB}));

    rdt(BASE + 32'(WIN), 1'b0);
    drain();
    check("oob_err", 64'(last_err), 64'(1));
    check("oob_rdata", 64'(last_rdata), 64'(0));
    rdt(BASE + 32'h2, 1'b1);
    drain();
    check("cap_misalign_err", 64'(last_err), 64'(1));
    wr(BASE + 32'h20, {1'b1, 32'hFFFF_FFFF}, 4'h3, 1'b1);
    drain();
    check("cap_be_err", 64'(last_err), 64'(1));
    rdt(BASE + 32'h20, 1'b1);
    drain();
    check("cap_be_nowrite", 64'(last_rdata), 64'({1'b0, 32'h1234_5678}));

    random_phase(300);

    // Latency-3 instance: throttling, stall and reset cases.
    sel = 1;
    prewrite();
    drain();
    for (int i = 0; i < 6; i++) rdt(BASE + 32'(i * 4), 1'b0);
    drain();
    issue(1'b0, 1'b0, 4'hF, BASE + 32'h8, 33'h0, 4, w);
    check("stall_release", 64'(w), 64'(5));
    drain();

    random_phase(300);

    wr(BASE + 32'hC, {1'b1, 32'hCAFE_0000}, 4'hF, 1'b1);
    rdt(BASE + 32'hC, 1'b1);
    drain();
    check("pre_rst_tag", 64'(last_rdata), 64'({1'b1, 32'hCAFE_0000}));
    rdt(BASE + 32'h0, 1'b0);
    rdt(BASE + 32'h4, 1'b0);
    do_reset();
    repeat (6) cycle();
    rdt(BASE + 32'hC, 1'b1);
    drain();
    check("post_rst_tag", 64'(last_rdata), 64'({1'b0, 32'hCAFE_0000}));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
